hazard_ctrl: RTL and testbench

Pipeline controller that sequences the execute-stage ALU in the 5-stage core.
- Detects load-use hazards and stalls IF/ID while injecting a bubble into EX.
- Drives registered operand-forwarding selects for the ALU input muxes.
- Flushes wrong-path instructions after a taken branch/jal/jalr reported by the ALU.
- Keeps saturating stall and flush event counters.

---
 rtl/core_pkg.sv | 54 +++++
 rtl/hazard_src_decode.sv | 37 +++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, mux-select and pipeline-control definitions for the 5-stage core
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    // An instruction now in EX will be in MEM when the consumer reaches EX, hence FWD_MEM;
    // the EX match wins because it is the younger producer.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       used,
        input logic [4:0] ex_rd,
        input logic       ex_we,
        input logic       ex_is_load,
        input logic [4:0] mem_rd,
        input logic       mem_we
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && src != 5'd0) begin
            if (ex_we && !ex_is_load && ex_rd == src) begin
                sel = FWD_MEM;
            end else if (mem_we && mem_rd == src) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// rtl/hazard_src_decode.sv - extracts source registers and their usage from an RV32I instruction
module hazard_src_decode
    import core_pkg::*;
(
    input  logic [31:0] id_instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic unused_bits;

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

    // Opcode class decides which source fields are real register reads
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_instr[6:0])
            OP_R, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                uses_rs1 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and operand-forwarding control for the EX stage
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        id_instr,
    input  logic               id_valid,
    input  logic [4:0]         ex_rd,
    input  logic               ex_we,
    input  logic               ex_is_load,
    input  logic [4:0]         mem_rd,
    input  logic               mem_we,
    input  logic               branch,
    input  logic               jalr,
    output logic               stall_if,
    output logic               stall_id,
    output logic               flush_id,
    output logic               flush_ex,
    output logic [1:0]         pc_sel,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam logic [2:0]         FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX    = '1;

    hz_state_e          state_q;
    logic [2:0]         flush_cnt_q;
    logic [1:0]         fwd_a_q, fwd_b_q;
    logic [1:0]         fwd_a_d, fwd_b_d;
    logic [COUNT_W-1:0] stall_count_q, flush_count_q;

    logic [4:0] rs1, rs2;
    logic       uses_rs1, uses_rs2;
    logic       load_use;

    hazard_src_decode u_src_decode (
        .id_instr (id_instr),
        .rs1      (rs1),
        .rs2      (rs2),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // A load result is not available until WB, so a consumer right behind it must wait one cycle
    always_comb begin
        load_use = id_valid && ex_we && ex_is_load && (ex_rd != 5'd0) &&
                   ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
    end

    // Mealy pipeline controls; a taken branch outranks a load-use stall since the consumer is wrong-path
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        pc_sel   = PC_PLUS4;
        if (reset) begin
            case (state_q)
                ST_RUN: begin
                    if (branch) begin
                        pc_sel   = jalr ? PC_JALR : PC_BRANCH;
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end
                default: begin
                    pc_sel = PC_PLUS4;
                end
            endcase
        end
    end

    // Forward selects for the instruction about to enter EX
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (id_valid) begin
            fwd_a_d = fwd_select(rs1, uses_rs1, ex_rd, ex_we, ex_is_load, mem_rd, mem_we);
            fwd_b_d = fwd_select(rs2, uses_rs2, ex_rd, ex_we, ex_is_load, mem_rd, mem_we);
        end
    end

    // Forward registers: a stalled ID holds them, a bubble into EX clears them
    always_ff @(posedge clock) begin
        if (!reset) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (stall_id) begin
            fwd_a_q <= fwd_a_q;
            fwd_b_q <= fwd_b_q;
        end else if (flush_ex) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // RUN/FLUSH sequencing with saturating event counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 3'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (branch) begin
                        if (flush_count_q != CNT_MAX) begin
                            flush_count_q <= flush_count_q + 1'b1;
                        end
                        if (FLUSH_CYCLES > 1) begin
                            state_q     <= ST_FLUSH;
                            flush_cnt_q <= FLUSH_LOAD;
                        end
                    end else if (load_use) begin
                        if (stall_count_q != CNT_MAX) begin
                            stall_count_q <= stall_count_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q <= 3'd1) begin
                        state_q     <= ST_RUN;
                        flush_cnt_q <= 3'd0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural pipeline model
module tb_hazard_ctrl;

    localparam int FC   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   id_instr;
    logic          id_valid;
    logic [4:0]    ex_rd;
    logic          ex_we;
    logic          ex_is_load;
    logic [4:0]    mem_rd;
    logic          mem_we;
    logic          branch;
    logic          jalr;
    logic          stall_if, stall_id, flush_id, flush_ex;
    logic [1:0]    pc_sel, fwd_a, fwd_b;
    logic [CW-1:0] stall_count, flush_count;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    int m_left = 0, m_fa = 0, m_fb = 0, m_sc = 0, m_fc = 0;
    int e_sif, e_sid, e_fid, e_fex, e_pc;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .COUNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_is_load  (ex_is_load),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .branch      (branch),
        .jalr        (jalr),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .flush_ex    (flush_ex),
        .pc_sel      (pc_sel),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // bit0 = reads rs1, bit1 = reads rs2
    function automatic int src_mask(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: return 3;
            7'b0010011, 7'b0000011, 7'b1100111: return 1;
            default:                            return 0;
        endcase
    endfunction

    function automatic bit reads(input logic [4:0] r);
        int m;
        m = src_mask(id_instr[6:0]);
        return ((m & 1) != 0 && id_instr[19:15] == r) || ((m & 2) != 0 && id_instr[24:20] == r);
    endfunction

    function automatic int want_fwd(input logic [4:0] s, input bit used);
        if (!id_valid || !used || s == 5'd0) return 0;
        if (ex_we && !ex_is_load && ex_rd == s) return 1;
        if (mem_we && mem_rd == s) return 2;
        return 0;
    endfunction

    task automatic model_comb();
        e_sif = 0; e_sid = 0; e_fid = 0; e_fex = 0; e_pc = 0;
        if (reset) begin
            if (m_left > 0) begin
                e_fid = 1; e_fex = 1;
            end else if (branch) begin
                e_pc = jalr ? 2 : 1; e_fid = 1; e_fex = 1;
            end else if (id_valid && ex_we && ex_is_load && ex_rd != 5'd0 && reads(ex_rd)) begin
                e_sif = 1; e_sid = 1; e_fex = 1;
            end
        end
    endtask

    always @(posedge clock) begin
        model_comb();
        if (!reset) begin
            m_left = 0; m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (!e_sid) begin
                if (e_fex) begin
                    m_fa = 0; m_fb = 0;
                end else begin
                    m_fa = want_fwd(id_instr[19:15], (src_mask(id_instr[6:0]) & 1) != 0);
                    m_fb = want_fwd(id_instr[24:20], (src_mask(id_instr[6:0]) & 2) != 0);
                end
            end
            if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (branch) begin
                if (m_fc < CMAX) m_fc = m_fc + 1;
                m_left = FC - 1;
            end else if (e_sid) begin
                if (m_sc < CMAX) m_sc = m_sc + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            model_comb();
            chk("stall_if", stall_if, e_sif);
            chk("stall_id", stall_id, e_sid);
            chk("flush_id", flush_id, e_fid);
            chk("flush_ex", flush_ex, e_fex);
            chk("pc_sel", pc_sel, e_pc);
            chk("fwd_a", fwd_a, m_fa);
            chk("fwd_b", fwd_b, m_fb);
            chk("stall_count", stall_count, m_sc);
            chk("flush_count", flush_count, m_fc);
        end
    end

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [6:0] op);
        return {7'd0, s2, s1, 3'd0, rd, op};
    endfunction

    task automatic idle();
        id_valid = 0; id_instr = 32'd0; ex_rd = 0; ex_we = 0; ex_is_load = 0;
        mem_rd = 0; mem_we = 0; branch = 0; jalr = 0;
    endtask

    task automatic lw_then_add();
        ex_we = 1; ex_is_load = 1; ex_rd = 5'd5;
        id_valid = 1; id_instr = rtype(5'd6, 5'd5, 5'd7, 7'b0110011);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    logic [6:0]  ops [10];
    logic [31:0] rnd;

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        idle();

        // reset held with a branch and a hazard present
        reset = 0; lw_then_add(); branch = 1; jalr = 1;
        cyc();
        chk_en = 1;
        repeat (3) begin
            smp();
            chk("rst_stall_if", stall_if, 0);
            chk("rst_flush_id", flush_id, 0);
            chk("rst_pc_sel", pc_sel, 0);
            chk("rst_stall_count", stall_count, 0);
            cyc();
        end
        reset = 1; idle();
        smp();
        chk("idle_pc_sel", pc_sel, 0);
        chk("idle_fwd_a", fwd_a, 0);
        chk("idle_flush_count", flush_count, 0);
        cyc();

        // lw x5 then add x6,x5,x7
        lw_then_add();
        smp();
        chk("lu_stall_if", stall_if, 1);
        chk("lu_stall_id", stall_id, 1);
        chk("lu_flush_ex", flush_ex, 1);
        chk("lu_flush_id", flush_id, 0);
        cyc();
        ex_we = 0; ex_is_load = 0; ex_rd = 0; mem_we = 1; mem_rd = 5'd5;
        smp();
        chk("lu_after_stall_if", stall_if, 0);
        chk("lu_stall_count", stall_count, 1);
        cyc();
        idle();
        smp();
        chk("lu_fwd_a", fwd_a, 2);
        chk("lu_fwd_b", fwd_b, 0);
        cyc();

        // addi x3 then sub x4,x1,x3; then a producer of x0
        ex_we = 1; ex_rd = 5'd3; id_valid = 1; id_instr = rtype(5'd4, 5'd1, 5'd3, 7'b0110011);
        smp();
        chk("ex_fwd_no_stall", stall_if, 0);
        cyc();
        ex_rd = 5'd0; id_instr = rtype(5'd4, 5'd1, 5'd0, 7'b0110011);
        smp();
        chk("ex_fwd_b", fwd_b, 1);
        chk("ex_fwd_a", fwd_a, 0);
        cyc();
        idle();
        smp();
        chk("x0_fwd_b", fwd_b, 0);
        cyc();

        // jalr taken together with a load-use hazard, second branch pulse ignored
        lw_then_add(); branch = 1; jalr = 1;
        smp();
        chk("br_pc_sel", pc_sel, 2);
        chk("br_flush_id", flush_id, 1);
        chk("br_flush_ex", flush_ex, 1);
        chk("br_stall_if", stall_if, 0);
        cyc();
        jalr = 0;
        smp();
        chk("fl_pc_sel", pc_sel, 0);
        chk("fl_flush_id", flush_id, 1);
        chk("fl_stall_if", stall_if, 0);
        cyc();
        idle();
        smp();
        chk("post_flush_id", flush_id, 0);
        chk("br_flush_count", flush_count, 1);
        chk("br_stall_count", stall_count, 1);
        cyc();

        // stall counter saturation
        repeat (5) begin
            lw_then_add();
            cyc();
            idle();
            cyc();
        end
        smp();
        chk("sat_stall_count", stall_count, 3);
        cyc();

        // reset in the first FLUSH cycle
        branch = 1;
        cyc();
        branch = 0; reset = 0;
        smp();
        chk("rst_in_flush_id", flush_id, 0);
        cyc();
        reset = 1;
        smp();
        chk("after_rst_flush_id", flush_id, 0);
        chk("after_rst_flush_count", flush_count, 0);
        cyc();

        // mixed vector sweep checked by the model
        repeat (300) begin
            rnd = $urandom;
            rnd[6:0]   = ops[$urandom_range(0, 9)];
            rnd[19:15] = 5'($urandom_range(0, 7));
            rnd[24:20] = 5'($urandom_range(0, 7));
            id_instr   = rnd;
            id_valid   = ($urandom_range(0, 4) != 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_we      = 1'($urandom_range(0, 1));
            ex_is_load = 1'($urandom_range(0, 1));
            mem_rd     = 5'($urandom_range(0, 7));
            mem_we     = 1'($urandom_range(0, 1));
            branch     = ($urandom_range(0, 5) == 0);
            jalr       = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 40) != 0);
            cyc();
        end
        reset = 1; idle();
        repeat (3) cyc();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
